// File: rtl/bridge_tx_sched_pkg.sv
// Shared definitions for the bridge transmit sequencer:
// FSM state encoding, default timing constants and counter sizing.
package bridge_tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_FETCH = 3'd2,
        ST_LOAD  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_GAP   = 3'd5
    } state_e;

    localparam int unsigned DEF_FIFO_RD_LAT    = 1;
    localparam int unsigned DEF_GAP_CYCLES     = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

    // Bits needed to hold max_load, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_load);
        return (max_load < 1) ? 1 : $clog2(max_load + 1);
    endfunction

endpackage

// File: rtl/bridge_tx_sched_down_counter.sv
// Loadable down counter used for the FIFO latency, inter-byte gap
// and transmit timeout counts.
module down_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High when a decrement in this cycle lands the count on zero.
    assign zero = (cnt_q <= W'(1));

endmodule

// File: rtl/bridge_tx_sched.sv
// Transmit sequencer: pops bytes from the bridge FIFO, strobes them
// into the UART, waits for completion and enforces an inter-byte gap.
module bridge_tx_sched
    import bridge_tx_sched_pkg::*;
#(
    parameter int unsigned FIFO_RD_LAT    = DEF_FIFO_RD_LAT,
    parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data,
    output logic             fifo_rd_en,
    input  logic             tx_active,
    input  logic             tx_done,
    output logic             tx_dv,
    output logic [7:0]       tx_byte,
    input  logic             hold,
    output logic             busy,
    output logic [CNT_W-1:0] byte_count,
    output logic             timeout_err
);

    localparam int unsigned LMAX =
        (FIFO_RD_LAT > GAP_CYCLES) ? FIFO_RD_LAT : GAP_CYCLES;
    localparam int unsigned LW = cnt_width(LMAX);
    localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);

    state_e             state_q, state_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic [CNT_W-1:0]   byte_count_q, byte_count_d;
    logic               timeout_err_q, timeout_err_d;

    logic               lat_load, lat_dec, lat_zero;
    logic [LW-1:0]      lat_val;
    logic               to_load, to_dec, to_zero;

    // One counter serves both FIFO latency and the gap; they never overlap.
    down_counter #(.W(LW)) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (lat_load),
        .load_val (lat_val),
        .dec      (lat_dec),
        .zero     (lat_zero)
    );

    down_counter #(.W(TW)) u_to_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (to_load),
        .load_val (TW'(TIMEOUT_CYCLES)),
        .dec      (to_dec),
        .zero     (to_zero)
    );

    always_comb begin
        state_d       = state_q;
        tx_byte_d     = tx_byte_q;
        byte_count_d  = byte_count_q;
        timeout_err_d = timeout_err_q;
        lat_load      = 1'b0;
        lat_val       = LW'(FIFO_RD_LAT);
        lat_dec       = 1'b0;
        to_load       = 1'b0;
        to_dec        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !hold && !tx_active) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                lat_load = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_FETCH: begin
                lat_dec = 1'b1;
                if (lat_zero) begin
                    tx_byte_d = fifo_data;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                to_load = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                to_dec = 1'b1;
                // Completion wins over a timeout expiring in the same cycle.
                if (tx_done) begin
                    byte_count_d = byte_count_q + CNT_W'(1);
                    if (GAP_CYCLES > 0) begin
                        lat_load = 1'b1;
                        lat_val  = LW'(GAP_CYCLES);
                        state_d  = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (to_zero) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_GAP: begin
                lat_dec = 1'b1;
                if (lat_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            tx_byte_q     <= 8'h00;
            byte_count_q  <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_byte_q     <= tx_byte_d;
            byte_count_q  <= byte_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign fifo_rd_en  = (state_q == ST_POP);
    assign tx_dv       = (state_q == ST_LOAD);
    assign busy        = (state_q != ST_IDLE);
    assign tx_byte     = tx_byte_q;
    assign byte_count  = byte_count_q;
    assign timeout_err = timeout_err_q;

endmodule
